// File: rtl/mcs6530_pkg.sv
// Shared types and constants for the MCS6530 bus-cycle controller.
//   target_e      : decoded access target (none, ROM, RAM, port registers, timer)
//   state_e       : bus-cycle FSM states
//   IoReg*        : port register indices driven on io_reg
//   *SelDefault   : addr[7:6] codes that select RAM and I/O/timer space
//   decode_target : priority decode of one bus cycle
package mcs6530_pkg;

    typedef enum logic [2:0] {
        TgtNone,
        TgtRom,
        TgtRam,
        TgtIo,
        TgtTmr
    } target_e;

    typedef enum logic [1:0] {
        StGuard,
        StIdle,
        StRd,
        StWr
    } state_e;

    localparam logic [1:0] IoRegPa   = 2'd0;
    localparam logic [1:0] IoRegDdra = 2'd1;
    localparam logic [1:0] IoRegPb   = 2'd2;
    localparam logic [1:0] IoRegDdrb = 2'd3;

    localparam logic [1:0] RamSelDefault = 2'b11;
    localparam logic [1:0] IoSelDefault  = 2'b01;

    // ROM select wins over chip select; inside the chip, addr[2] splits
    // the I/O window into port registers and timer.
    function automatic target_e decode_target(input logic       cs,
                                              input logic       rs_n,
                                              input logic [1:0] page,
                                              input logic       a2,
                                              input logic [1:0] ram_sel,
                                              input logic [1:0] io_sel);
        if (!rs_n)                   return TgtRom;
        if (cs && page == ram_sel)   return TgtRam;
        if (cs && page == io_sel)    return a2 ? TgtTmr : TgtIo;
        return TgtNone;
    endfunction

endpackage

// File: rtl/mcs6530_bus_ctrl_if.sv
// Bundle between the bus-cycle controller and the rest of the MCS6530 core.
//   pad side    : cs, rs_n, we_n, addr, di in; dout, oe out
//   ROM         : rom_addr, rom_rd out; rom_q in
//   RAM         : ram_addr, ram_rd, ram_we out; ram_q in
//   port regs   : io_reg, io_we out; io_q in
//   timer       : tmr_we, tmr_prescale, tmr_irq_en, tmr_rd out; tmr_cnt, tmr_flag in
//   wdata       : write data shared by all targets
// master = the controller, slave = pads and targets.
interface mcs6530_bus_ctrl_if;

    logic       cs;
    logic       rs_n;
    logic       we_n;
    logic [9:0] addr;
    logic [7:0] di;

    logic [9:0] rom_addr;
    logic       rom_rd;
    logic [7:0] rom_q;
    logic [5:0] ram_addr;
    logic       ram_rd;
    logic       ram_we;
    logic [7:0] ram_q;
    logic [1:0] io_reg;
    logic       io_we;
    logic [7:0] io_q;
    logic       tmr_we;
    logic [1:0] tmr_prescale;
    logic       tmr_irq_en;
    logic       tmr_rd;
    logic [7:0] tmr_cnt;
    logic       tmr_flag;

    logic [7:0] wdata;
    logic [7:0] dout;
    logic       oe;

    modport master (
        input  cs, rs_n, we_n, addr, di, rom_q, ram_q, io_q, tmr_cnt, tmr_flag,
        output rom_addr, rom_rd, ram_addr, ram_rd, ram_we, io_reg, io_we,
               tmr_we, tmr_prescale, tmr_irq_en, tmr_rd, wdata, dout, oe
    );

    modport slave (
        output cs, rs_n, we_n, addr, di, rom_q, ram_q, io_q, tmr_cnt, tmr_flag,
        input  rom_addr, rom_rd, ram_addr, ram_rd, ram_we, io_reg, io_we,
               tmr_we, tmr_prescale, tmr_irq_en, tmr_rd, wdata, dout, oe
    );

endinterface

// File: rtl/mcs6530_bus_ctrl.sv
// Bus-cycle controller for the MCS6530 core.
// Decodes each phi2 cycle, issues one target strobe in the decode cycle,
// and presents read data with oe during the following cycle.
// Ports:
//   phi2 : clock, all state on the rising edge
//   rst  : asynchronous reset, active high
//   bus  : controller side (master) of mcs6530_bus_ctrl_if
module mcs6530_bus_ctrl
    import mcs6530_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 2,
    parameter logic [1:0]  RAM_SEL      = RamSelDefault,
    parameter logic [1:0]  IO_SEL       = IoSelDefault
) (
    input logic                 phi2,
    input logic                 rst,
    mcs6530_bus_ctrl_if.master  bus
);

    localparam logic [7:0] GuardInit = 8'(GUARD_CYCLES);

    state_e     state_q;
    logic [7:0] guard_cnt_q;
    logic       oe_q;
    target_e    src_tgt_q;
    logic       src_status_q;
    logic [7:0] hold_q;
    logic       irq_en_q;

    target_e    tgt;
    logic       live;
    logic       rd_go;
    logic       wr_go;

    assign tgt  = decode_target(bus.cs, bus.rs_n, bus.addr[7:6], bus.addr[2], RAM_SEL, IO_SEL);
    // Guard state doubles as the reset gate: rst forces it asynchronously,
    // which kills every strobe in the same instant.
    assign live  = (state_q != StGuard);
    assign rd_go = live && bus.we_n && (tgt != TgtNone);
    assign wr_go = live && !bus.we_n && (tgt inside {TgtRam, TgtIo, TgtTmr});

    assign bus.rom_addr     = bus.addr;
    assign bus.ram_addr     = bus.addr[5:0];
    assign bus.io_reg       = bus.addr[1:0];
    assign bus.wdata        = bus.di;
    assign bus.rom_rd       = rd_go && (tgt == TgtRom);
    assign bus.ram_rd       = rd_go && (tgt == TgtRam);
    assign bus.ram_we       = wr_go && (tgt == TgtRam);
    assign bus.io_we        = wr_go && (tgt == TgtIo);
    assign bus.tmr_we       = wr_go && (tgt == TgtTmr);
    assign bus.tmr_rd       = rd_go && (tgt == TgtTmr) && !bus.addr[0];
    assign bus.tmr_prescale = bus.tmr_we ? bus.addr[1:0] : 2'b00;
    assign bus.tmr_irq_en   = irq_en_q;
    assign bus.oe           = oe_q;

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            state_q      <= StGuard;
            guard_cnt_q  <= GuardInit;
            oe_q         <= 1'b0;
            src_tgt_q    <= TgtNone;
            src_status_q <= 1'b0;
            hold_q       <= 8'h00;
            irq_en_q     <= 1'b0;
        end else if (state_q == StGuard) begin
            // Leave guard on the edge where the counter lands on zero.
            if (guard_cnt_q <= 8'd1) state_q <= StIdle;
            if (guard_cnt_q != 8'd0) guard_cnt_q <= guard_cnt_q - 8'd1;
            oe_q <= 1'b0;
        end else begin
            state_q <= rd_go ? StRd : (wr_go ? StWr : StIdle);
            oe_q    <= rd_go;
            if (rd_go) begin
                src_tgt_q    <= tgt;
                src_status_q <= (tgt == TgtTmr) && bus.addr[0];
                // io_q follows io_reg combinationally and the address moves on
                // next cycle, so port and count bytes are captured now.
                hold_q       <= (tgt == TgtTmr) ? bus.tmr_cnt : bus.io_q;
            end
            if (tgt == TgtTmr) irq_en_q <= bus.addr[3];
        end
    end

    // ROM and RAM answer one cycle late; the flag is sampled live in k+1.
    always_comb begin
        bus.dout = 8'h00;
        if (oe_q) begin
            case (src_tgt_q)
                TgtRom:  bus.dout = bus.rom_q;
                TgtRam:  bus.dout = bus.ram_q;
                TgtIo:   bus.dout = hold_q;
                TgtTmr:  bus.dout = src_status_q ? {bus.tmr_flag, 7'b0} : hold_q;
                default: bus.dout = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_mcs6530_bus_ctrl.sv
// Self-checking bench for mcs6530_bus_ctrl: directed vector table, a reset
// sequence, then randomized cycles against a cycle-level reference model.
module tb_mcs6530_bus_ctrl;

    localparam int Guard = 2;
    localparam int NumVec = 17;
    localparam int NumRand = 600;

    logic phi2 = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mcs6530_bus_ctrl_if bus();

    mcs6530_bus_ctrl dut (
        .phi2 (phi2),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 phi2 = ~phi2;

    // {rom_rd, ram_rd, ram_we, io_we, tmr_we, tmr_rd}
    logic [5:0] strb;
    assign strb = {bus.rom_rd, bus.ram_rd, bus.ram_we, bus.io_we, bus.tmr_we, bus.tmr_rd};

    function automatic logic [7:0] rom_fn(input logic [9:0] a);
        return a[7:0] ^ 8'h55 ^ {a[9:8], 6'b0} ^ 8'hC0;
    endfunction

    function automatic logic [7:0] io_fn(input logic [1:0] r);
        return 8'hA4 | {6'b0, r};
    endfunction

    // Target models: ROM and RAM answer one cycle after their strobe.
    logic [7:0] ram_img [64];
    assign bus.io_q = io_fn(bus.io_reg);

    always @(posedge phi2 or posedge rst) begin
        if (rst) begin
            bus.rom_q <= 8'h00;
            bus.ram_q <= 8'h00;
            for (int i = 0; i < 64; i++) ram_img[i] <= 8'h00;
        end else begin
            if (bus.rom_rd) bus.rom_q <= rom_fn(bus.rom_addr);
            if (bus.ram_rd) bus.ram_q <= ram_img[bus.ram_addr];
            if (bus.ram_we) ram_img[bus.ram_addr] <= bus.wdata;
        end
    end

    typedef struct {
        logic       cs;
        logic       rs_n;
        logic       we_n;
        logic [9:0] addr;
        logic [7:0] di;
        logic [7:0] tcnt;
        logic       flag;
        logic [5:0] e_strb;
        logic       e_oe;
        logic [7:0] e_dout;
        logic       e_irq;
        logic [1:0] e_pre;
    } vec_t;

    vec_t tbl [NumVec];

    function automatic vec_t mk(input logic cs, rs_n, we_n, input logic [9:0] addr,
                                input logic [7:0] di, tcnt, input logic flag,
                                input logic [5:0] e_strb, input logic e_oe,
                                input logic [7:0] e_dout, input logic e_irq,
                                input logic [1:0] e_pre);
        vec_t v;
        v.cs = cs; v.rs_n = rs_n; v.we_n = we_n; v.addr = addr; v.di = di;
        v.tcnt = tcnt; v.flag = flag; v.e_strb = e_strb; v.e_oe = e_oe;
        v.e_dout = e_dout; v.e_irq = e_irq; v.e_pre = e_pre;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cs, rs_n, we_n, input logic [9:0] addr,
                         input logic [7:0] di, tcnt, input logic flag);
        bus.cs = cs; bus.rs_n = rs_n; bus.we_n = we_n; bus.addr = addr;
        bus.di = di; bus.tmr_cnt = tcnt; bus.tmr_flag = flag;
    endtask

    // Reference model state
    int         guard_left;
    logic       pend_oe;
    logic       pend_stat;
    logic [7:0] pend_val;
    logic       irq_m;
    logic [7:0] mem [64];

    initial begin
        // Row inputs and the values expected during that same cycle.
        tbl[0]  = mk(1, 0, 1, 10'h3FC, 8'h00, 8'h00, 0, 6'b000000, 0, 8'h00, 0, 2'd0);
        tbl[1]  = mk(1, 0, 1, 10'h3FC, 8'h00, 8'h00, 0, 6'b000000, 0, 8'h00, 0, 2'd0);
        tbl[2]  = mk(1, 0, 1, 10'h3FC, 8'h00, 8'h00, 0, 6'b100000, 0, 8'h00, 0, 2'd0);
        tbl[3]  = mk(1, 1, 0, 10'h0FF, 8'h5A, 8'h00, 0, 6'b001000, 1, 8'hA9, 0, 2'd0);
        tbl[4]  = mk(1, 1, 1, 10'h0FF, 8'h00, 8'h00, 0, 6'b010000, 0, 8'h00, 0, 2'd0);
        tbl[5]  = mk(1, 1, 0, 10'h04D, 8'h33, 8'h00, 0, 6'b000010, 1, 8'h5A, 0, 2'd1);
        tbl[6]  = mk(1, 1, 1, 10'h04D, 8'h00, 8'h00, 0, 6'b000000, 0, 8'h00, 1, 2'd0);
        tbl[7]  = mk(1, 1, 1, 10'h04C, 8'h00, 8'h77, 1, 6'b000001, 1, 8'h80, 1, 2'd0);
        tbl[8]  = mk(1, 1, 1, 10'h042, 8'h00, 8'h00, 0, 6'b000000, 1, 8'h77, 1, 2'd0);
        tbl[9]  = mk(1, 1, 0, 10'h043, 8'h11, 8'h00, 0, 6'b000100, 1, 8'hA6, 1, 2'd0);
        tbl[10] = mk(0, 1, 1, 10'h0FF, 8'h00, 8'h00, 0, 6'b000000, 0, 8'h00, 1, 2'd0);
        tbl[11] = mk(1, 0, 0, 10'h123, 8'hEE, 8'h00, 0, 6'b000000, 0, 8'h00, 1, 2'd0);
        tbl[12] = mk(1, 1, 1, 10'h080, 8'h00, 8'h00, 0, 6'b000000, 0, 8'h00, 1, 2'd0);
        tbl[13] = mk(1, 1, 1, 10'h0FF, 8'h00, 8'h00, 0, 6'b010000, 0, 8'h00, 1, 2'd0);
        tbl[14] = mk(1, 1, 1, 10'h0C0, 8'h00, 8'h00, 0, 6'b010000, 1, 8'h5A, 1, 2'd0);
        tbl[15] = mk(0, 1, 1, 10'h0C0, 8'h00, 8'h00, 0, 6'b000000, 1, 8'h00, 1, 2'd0);
        tbl[16] = mk(0, 1, 1, 10'h0C0, 8'h00, 8'h00, 0, 6'b000000, 0, 8'h00, 1, 2'd0);

        // Reset with a ROM read already pending on the pads.
        drive(1, 0, 1, 10'h3FC, 8'h00, 8'h00, 0);
        repeat (3) @(posedge phi2);
        @(negedge phi2);
        chk("reset strobes", 32'(strb), 32'd0);
        chk("reset oe", 32'(bus.oe), 32'd0);
        chk("reset dout", 32'(bus.dout), 32'd0);
        chk("reset irq_en", 32'(bus.tmr_irq_en), 32'd0);
        chk("reset prescale", 32'(bus.tmr_prescale), 32'd0);

        @(posedge phi2); #1;
        rst = 1'b0;
        for (int i = 0; i < NumVec; i++) begin
            drive(tbl[i].cs, tbl[i].rs_n, tbl[i].we_n, tbl[i].addr, tbl[i].di,
                  tbl[i].tcnt, tbl[i].flag);
            @(negedge phi2);
            chk($sformatf("vec%0d strobes", i), 32'(strb), 32'(tbl[i].e_strb));
            chk($sformatf("vec%0d oe", i), 32'(bus.oe), 32'(tbl[i].e_oe));
            chk($sformatf("vec%0d dout", i), 32'(bus.dout), 32'(tbl[i].e_dout));
            chk($sformatf("vec%0d irq_en", i), 32'(bus.tmr_irq_en), 32'(tbl[i].e_irq));
            if (tbl[i].e_strb[1])
                chk($sformatf("vec%0d prescale", i), 32'(bus.tmr_prescale), 32'(tbl[i].e_pre));
            @(posedge phi2); #1;
        end

        // Mid-cycle reset while a read is being driven and another is strobing.
        drive(1, 1, 1, 10'h0FF, 8'h00, 8'h00, 0);
        @(posedge phi2); #1;
        @(negedge phi2);
        chk("pre-reset oe", 32'(bus.oe), 32'd1);
        chk("pre-reset ram_rd", 32'(bus.ram_rd), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async reset strobes", 32'(strb), 32'd0);
        chk("async reset oe", 32'(bus.oe), 32'd0);
        chk("async reset dout", 32'(bus.dout), 32'd0);

        // Randomized cycles against the reference model.
        guard_left = Guard;
        pend_oe    = 1'b0;
        pend_stat  = 1'b0;
        pend_val   = 8'h00;
        irq_m      = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        @(posedge phi2); #1;
        rst = 1'b0;
        for (int n = 0; n < NumRand; n++) begin
            logic       cs, rs_n, we_n, flag, live, rd;
            logic [9:0] addr;
            logic [7:0] di, tcnt, e_dout;
            logic [5:0] e_strb;
            int         t;  // 0 none, 1 ROM, 2 RAM, 3 port, 4 timer
            cs   = ($urandom_range(0, 4) != 0);
            rs_n = ($urandom_range(0, 4) != 0);
            we_n = $urandom_range(0, 1) == 1;
            addr = 10'($urandom);
            if ($urandom_range(0, 1) == 1) addr[5:3] = 3'b000;
            di   = 8'($urandom);
            tcnt = 8'($urandom);
            flag = $urandom_range(0, 1) == 1;
            drive(cs, rs_n, we_n, addr, di, tcnt, flag);

            if (!rs_n)                           t = 1;
            else if (cs && addr[7:6] == 2'b11)   t = 2;
            else if (cs && addr[7:6] == 2'b01)   t = addr[2] ? 4 : 3;
            else                                 t = 0;
            live = (guard_left == 0);
            rd   = we_n;
            e_strb = 6'b0;
            if (live) begin
                case (t)
                    1: e_strb[5] = rd;
                    2: begin e_strb[4] = rd; e_strb[3] = !rd; end
                    3: e_strb[2] = !rd;
                    4: begin e_strb[1] = !rd; e_strb[0] = rd && !addr[0]; end
                    default: ;
                endcase
            end
            e_dout = !pend_oe ? 8'h00 : (pend_stat ? {flag, 7'b0} : pend_val);

            @(negedge phi2);
            chk($sformatf("rnd%0d strobes", n), 32'(strb), 32'(e_strb));
            chk($sformatf("rnd%0d oe", n), 32'(bus.oe), 32'(pend_oe));
            chk($sformatf("rnd%0d dout", n), 32'(bus.dout), 32'(e_dout));
            chk($sformatf("rnd%0d irq_en", n), 32'(bus.tmr_irq_en), 32'(irq_m));
            chk($sformatf("rnd%0d wdata", n), 32'(bus.wdata), 32'(di));
            if (e_strb[5])
                chk($sformatf("rnd%0d rom_addr", n), 32'(bus.rom_addr), 32'(addr));
            if (e_strb[4] || e_strb[3])
                chk($sformatf("rnd%0d ram_addr", n), 32'(bus.ram_addr), 32'(addr[5:0]));
            if (live && t == 3)
                chk($sformatf("rnd%0d io_reg", n), 32'(bus.io_reg), 32'(addr[1:0]));
            if (e_strb[1])
                chk($sformatf("rnd%0d prescale", n), 32'(bus.tmr_prescale), 32'(addr[1:0]));

            pend_oe   = live && rd && (t != 0);
            pend_stat = (t == 4) && addr[0];
            case (t)
                1:       pend_val = rom_fn(addr);
                2:       pend_val = mem[addr[5:0]];
                3:       pend_val = io_fn(addr[1:0]);
                4:       pend_val = tcnt;
                default: pend_val = 8'h00;
            endcase
            if (live && t == 2 && !rd) mem[addr[5:0]] = di;
            if (live && t == 4) irq_m = addr[3];
            if (guard_left > 0) guard_left--;
            @(posedge phi2); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
